// File: rtl/uart_hub_pkg.sv
// Shared constants for the UART port hub: port map, status layout and
// drain FSM encoding.
package uart_hub_pkg;

  // Channel c uses base + 2c; hub registers sit above the channel window.
  localparam logic [3:0] RX_DATA  = 4'h0;
  localparam logic [3:0] RX_STAT  = 4'h1;
  localparam logic [3:0] LED      = 4'h8;
  localparam logic [3:0] IRQ_PEND = 4'h8;
  localparam logic [3:0] DISP_LO  = 4'h9;
  localparam logic [3:0] DISP_HI  = 4'hA;
  localparam logic [3:0] IRQ_MASK = 4'hB;

  // Status word layout for a channel status read.
  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_DROP   = 5;
  localparam int ST_COUNT     = 8;

  // TX drain: BLANK is the one-cycle gap after each load.
  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_BLANK = 1'b1
  } drain_state_e;

endpackage

// File: rtl/hub_fifo.sv
// Byte FIFO with a separate occupancy counter so that full is
// count == DEPTH. A push into a full FIFO is accepted only when a pop
// happens on the same edge. Head reads as zero while empty.
module hub_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,      // synchronous, active-low
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy; pointers wrap naturally.
  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_port_hub.sv
// Port-mapped hub between the TramelBlaze port bus and NCH UART engines:
// per-channel RX/TX FIFOs with sticky error flags, a maskable interrupt
// with ack handshake, and the LED / seven-segment display registers.
module uart_port_hub
  import uart_hub_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      port_id,
  input  logic [15:0]      out_port,
  input  logic             read_strobe,
  input  logic             write_strobe,
  input  logic             interrupt_ack,
  output logic [15:0]      in_port,
  output logic             interrupt,
  input  logic [NCH*8-1:0] rx_data,
  input  logic [NCH-1:0]   rx_valid,
  input  logic [NCH-1:0]   tx_ready,
  output logic [NCH*8-1:0] tx_data,
  output logic [NCH-1:0]   tx_load,
  output logic [7:0]       leds,
  output logic [15:0]      disp
);

  logic [3:0] addr;
  logic       unused_bits;

  assign addr        = port_id[3:0];
  assign unused_bits = ^{port_id[15:4], out_port[15:8]};

  logic [NCH-1:0] rx_pop, rx_full, rx_empty, rx_ovr_set;
  logic [NCH-1:0] tx_wr, tx_push, tx_full, tx_empty, flag_clr;
  logic [CW-1:0]  rx_cnt  [NCH];
  logic [CW-1:0]  tx_cnt  [NCH];
  logic [7:0]     rx_head [NCH];
  logic [7:0]     tx_head [NCH];

  logic [NCH-1:0] rx_ovr_q, tx_drop_q;
  drain_state_e   drain_q [NCH];

  logic [7:0]     leds_q;
  logic [15:0]    disp_q;
  logic [NCH-1:0] mask_q, pend;
  logic           irq_q, irq_d;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign rx_pop[c]   = read_strobe  & (addr == RX_DATA + 4'(2*c));
    assign tx_wr[c]    = write_strobe & (addr == RX_DATA + 4'(2*c));
    assign flag_clr[c] = write_strobe & (addr == RX_STAT + 4'(2*c));

    // A pop on the same edge frees a slot, so only a true overflow drops.
    assign rx_ovr_set[c] = rx_valid[c] & rx_full[c] & ~rx_pop[c];
    // TX writes are refused whenever the FIFO is full at the write edge.
    assign tx_push[c]    = tx_wr[c] & ~tx_full[c];

    // Load is offered straight from IDLE so the engine sees it the cycle
    // the byte becomes available; the pop lands on the same edge.
    assign tx_load[c] = rst & (drain_q[c] == DRAIN_IDLE) &
                        (tx_cnt[c] != '0) & tx_ready[c];
    assign tx_data[8*c +: 8] = tx_head[c];

    hub_fifo #(.DEPTH(DEPTH), .W(8), .CW(CW)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_valid[c]),
      .din_i   (rx_data[8*c +: 8]),
      .pop_i   (rx_pop[c]),
      .head_o  (rx_head[c]),
      .full_o  (rx_full[c]),
      .empty_o (rx_empty[c]),
      .count_o (rx_cnt[c])
    );

    hub_fifo #(.DEPTH(DEPTH), .W(8), .CW(CW)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push[c]),
      .din_i   (out_port[7:0]),
      .pop_i   (tx_load[c]),
      .head_o  (tx_head[c]),
      .full_o  (tx_full[c]),
      .empty_o (tx_empty[c]),
      .count_o (tx_cnt[c])
    );
  end

  // Sticky error flags and the per-channel drain FSMs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ovr_q  <= '0;
      tx_drop_q <= '0;
      for (int c = 0; c < NCH; c++) drain_q[c] <= DRAIN_IDLE;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        // A new overrun on the clearing edge is kept rather than lost.
        if (flag_clr[c]) begin
          rx_ovr_q[c]  <= 1'b0;
          tx_drop_q[c] <= 1'b0;
        end
        if (rx_ovr_set[c])           rx_ovr_q[c]  <= 1'b1;
        if (tx_wr[c] & tx_full[c])   tx_drop_q[c] <= 1'b1;
        case (drain_q[c])
          DRAIN_IDLE:  if (tx_load[c]) drain_q[c] <= DRAIN_BLANK;
          default:     drain_q[c] <= DRAIN_IDLE;
        endcase
      end
    end
  end

  // LED, display and interrupt mask registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      leds_q <= '0;
      disp_q <= '0;
      mask_q <= '1;
    end else if (write_strobe) begin
      case (addr)
        LED:      leds_q       <= out_port[7:0];
        DISP_LO:  disp_q[7:0]  <= out_port[7:0];
        DISP_HI:  disp_q[15:8] <= out_port[7:0];
        IRQ_MASK: mask_q       <= out_port[NCH-1:0];
        default:  ;
      endcase
    end
  end

  assign pend = ~rx_empty & mask_q;

  // Interrupt next-state: ack always wins, otherwise any pending sets it.
  always_comb begin
    irq_d = irq_q;
    if (interrupt_ack)  irq_d = 1'b0;
    else if (|pend)     irq_d = 1'b1;
  end

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  // Read mux, combinational from the port address.
  always_comb begin
    in_port = '0;
    for (int c = 0; c < NCH; c++) begin
      if (addr == RX_DATA + 4'(2*c)) begin
        in_port = {8'h00, rx_head[c]};
      end else if (addr == RX_STAT + 4'(2*c)) begin
        in_port[ST_RX_EMPTY]    = rx_empty[c];
        in_port[ST_RX_FULL]     = rx_full[c];
        in_port[ST_TX_EMPTY]    = tx_empty[c];
        in_port[ST_TX_FULL]     = tx_full[c];
        in_port[ST_RX_OVERRUN]  = rx_ovr_q[c];
        in_port[ST_TX_DROP]     = tx_drop_q[c];
        in_port[ST_COUNT +: CW] = rx_cnt[c];
      end
    end
    if (addr == IRQ_PEND)      in_port = 16'(pend);
    else if (addr == IRQ_MASK) in_port = 16'(mask_q);
  end

  assign interrupt = irq_q;
  assign leds      = leds_q;
  assign disp      = disp_q;

endmodule

// File: tb/tb_uart_port_hub.sv
// Randomised and directed bench for uart_port_hub against a queue-based
// reference model of the port map, FIFOs, drain spacing and interrupt.
module tb_uart_port_hub;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      port_id, out_port;
  logic             read_strobe, write_strobe, interrupt_ack;
  logic [15:0]      in_port;
  logic             interrupt;
  logic [NCH*8-1:0] rx_data;
  logic [NCH-1:0]   rx_valid, tx_ready;
  logic [NCH*8-1:0] tx_data;
  logic [NCH-1:0]   tx_load;
  logic [7:0]       leds;
  logic [15:0]      disp;

  always #5 clk = ~clk;

  uart_port_hub #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .port_id       (port_id),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_load       (tx_load),
    .leds          (leds),
    .disp          (disp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]     rxq [NCH][$];
  logic [7:0]     txq [NCH][$];
  bit             m_ovr  [NCH];
  bit             m_drop [NCH];
  int             m_last [NCH];
  logic [NCH-1:0] m_mask;
  logic [7:0]     m_leds;
  logic [15:0]    m_disp;
  bit             m_irq;
  logic [NCH-1:0] e_load;

  // Observations captured mid-cycle
  logic [15:0]      obs_in;
  logic             obs_irq;
  logic [NCH-1:0]   obs_load;
  logic [NCH*8-1:0] obs_txd;
  int               ld0_n;
  int               ld1_cyc [$];
  logic [7:0]       ld1_dat [$];

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      rxq[k].delete();
      txq[k].delete();
      m_ovr[k]  = 0;
      m_drop[k] = 0;
      m_last[k] = -10;
    end
    m_mask = '1;
    m_leds = '0;
    m_disp = '0;
    m_irq  = 0;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    int v;
    int c;
    v = 0;
    c = a / 2;
    if (a < 2*NCH) begin
      if (a % 2 == 0) begin
        if (rxq[c].size() > 0) v = int'(rxq[c][0]);
      end else begin
        if (rxq[c].size() == 0)     v += 1;
        if (rxq[c].size() == DEPTH) v += 2;
        if (txq[c].size() == 0)     v += 4;
        if (txq[c].size() == DEPTH) v += 8;
        if (m_ovr[c])               v += 16;
        if (m_drop[c])              v += 32;
        v += rxq[c].size() * 256;
      end
    end else if (a == 8) begin
      for (int k = 0; k < NCH; k++)
        if (rxq[k].size() > 0 && m_mask[k]) v += (1 << k);
    end else if (a == 11) begin
      v = int'(m_mask);
    end
    return 16'(v);
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int ai;
    logic [NCH-1:0] pend_v;
    @(negedge clk);
    ai = int'(port_id[3:0]);
    for (int k = 0; k < NCH; k++)
      e_load[k] = rst && (txq[k].size() > 0) && tx_ready[k] && (cyc - m_last[k] >= 2);
    obs_in   = in_port;
    obs_irq  = interrupt;
    obs_load = tx_load;
    obs_txd  = tx_data;
    check_eq("in_port", 32'(in_port), 32'(model_read(ai)));
    check_eq("interrupt", 32'(interrupt), 32'(m_irq));
    check_eq("tx_load", 32'(tx_load), 32'(e_load));
    for (int k = 0; k < NCH; k++)
      if (e_load[k]) check_eq("tx_data", 32'(tx_data[8*k +: 8]), 32'(txq[k][0]));
    check_eq("leds", 32'(leds), 32'(m_leds));
    check_eq("disp", 32'(disp), 32'(m_disp));
    if (obs_load[0]) ld0_n++;
    if (obs_load[1]) begin
      ld1_cyc.push_back(cyc);
      ld1_dat.push_back(obs_txd[15:8]);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NCH; k++) pend_v[k] = (rxq[k].size() > 0) && m_mask[k];
      for (int k = 0; k < NCH; k++) begin
        bit pop, full, tfull, ovr_set;
        full    = (rxq[k].size() == DEPTH);
        tfull   = (txq[k].size() == DEPTH);
        pop     = read_strobe && (ai == 2*k) && (rxq[k].size() > 0);
        ovr_set = 0;
        if (pop) void'(rxq[k].pop_front());
        if (rx_valid[k]) begin
          if (!full || pop) rxq[k].push_back(rx_data[8*k +: 8]);
          else              ovr_set = 1;
        end
        if (e_load[k]) begin
          void'(txq[k].pop_front());
          m_last[k] = cyc;
        end
        if (write_strobe && ai == 2*k) begin
          if (tfull) m_drop[k] = 1;
          else       txq[k].push_back(out_port[7:0]);
        end
        if (write_strobe && ai == 2*k+1) begin
          m_ovr[k]  = 0;
          m_drop[k] = 0;
        end
        if (ovr_set) m_ovr[k] = 1;
      end
      if (write_strobe) begin
        case (ai)
          8:       m_leds       = out_port[7:0];
          9:       m_disp[7:0]  = out_port[7:0];
          10:      m_disp[15:8] = out_port[7:0];
          11:      m_mask       = out_port[NCH-1:0];
          default: ;
        endcase
      end
      if (interrupt_ack)  m_irq = 0;
      else if (|pend_v)   m_irq = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input int a);
    port_id = 16'(a);
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    port_id  = 16'(a);
    out_port = {8'h00, d};
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rx_byte(input int c, input logic [7:0] d);
    rx_data[8*c +: 8] = d;
    rx_valid[c] = 1'b1;
    step();
    rx_valid = '0;
  endtask

  initial begin
    int wcyc;
    rst = 1'b0; port_id = '0; out_port = '0; read_strobe = 1'b0;
    write_strobe = 1'b0; interrupt_ack = 1'b0; rx_data = '0;
    rx_valid = '0; tx_ready = '0; ld0_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    port_id = 16'h000B;
    step();
    check_eq("rst_mask", 32'(obs_in), 32'h0003);
    check_eq("rst_irq", 32'(obs_irq), 32'h0);
    check_eq("rst_load", 32'(obs_load), 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h00);
    check_eq("rst_disp", 32'(disp), 32'h0000);

    // RX overflow on channel 0
    for (int i = 0; i < 9; i++) rx_byte(0, 8'(8'h10 + i));
    port_id = 16'h0001;
    step();
    check_eq("ovr_stat", 32'(obs_in), 32'h0816);
    for (int i = 0; i < 8; i++) begin
      rd(0);
      check_eq("ovr_pop", 32'(obs_in), 32'(16'h10 + i));
    end
    rd(0);
    check_eq("empty_pop", 32'(obs_in), 32'h0);
    wr(1, 8'h00);
    port_id = 16'h0001;
    step();
    check_eq("ovr_clr", 32'(obs_in), 32'h0005);

    // Push and pop on a full channel 1
    for (int i = 0; i < 8; i++) rx_byte(1, 8'(8'h20 + i));
    rx_data[15:8] = 8'h28; rx_valid[1] = 1'b1;
    port_id = 16'h0002; read_strobe = 1'b1;
    step();
    rx_valid = '0; read_strobe = 1'b0;
    check_eq("pp_head", 32'(obs_in), 32'h0020);
    port_id = 16'h0003;
    step();
    check_eq("pp_stat", 32'(obs_in), 32'h0806);
    for (int i = 0; i < 8; i++) begin
      rd(2);
      check_eq("pp_order", 32'(obs_in), 32'(16'h21 + i));
    end

    // TX drain spacing on channel 1
    tx_ready = 2'b11;
    ld1_cyc.delete(); ld1_dat.delete();
    wcyc = cyc;
    wr(2, 8'hA5);
    wr(2, 8'h5A);
    idle(4);
    check_eq("tx_nload", 32'(ld1_cyc.size()), 32'd2);
    if (ld1_cyc.size() == 2) begin
      check_eq("tx_lat", 32'(ld1_cyc[0] - wcyc), 32'd1);
      check_eq("tx_d0", 32'(ld1_dat[0]), 32'hA5);
      check_eq("tx_d1", 32'(ld1_dat[1]), 32'h5A);
      check_eq("tx_gap", 32'(ld1_cyc[1] - ld1_cyc[0]), 32'd2);
    end

    // No load while the engine is busy
    tx_ready = 2'b00;
    ld0_n = 0;
    wr(0, 8'h77);
    idle(4);
    check_eq("tx_hold", 32'(ld0_n), 32'd0);
    tx_ready = 2'b11;
    idle(3);
    check_eq("tx_release", 32'(ld0_n), 32'd1);

    // Interrupt masking, ack and re-assertion
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    wr(11, 8'h01);
    rx_byte(1, 8'h99);
    idle(3);
    check_eq("irq_masked", 32'(obs_irq), 32'h0);
    wr(11, 8'h03);
    idle(2);
    check_eq("irq_unmask", 32'(obs_irq), 32'h1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    step();
    check_eq("irq_ack_low", 32'(obs_irq), 32'h0);
    step();
    check_eq("irq_reassert", 32'(obs_irq), 32'h1);
    interrupt_ack = 1'b1;
    rd(2);
    interrupt_ack = 1'b0;
    check_eq("irq_pop", 32'(obs_in), 32'h0099);
    idle(3);
    check_eq("irq_stays_low", 32'(obs_irq), 32'h0);

    // Display and LEDs
    wr(9, 8'h34);
    wr(10, 8'h12);
    wr(8, 8'hFF);
    check_eq("disp_val", 32'(disp), 32'h1234);
    check_eq("leds_val", 32'(leds), 32'hFF);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 799) != 0);
      port_id       = 16'($urandom);
      out_port      = 16'($urandom);
      read_strobe   = ($urandom_range(0, 2) == 0);
      write_strobe  = !read_strobe && ($urandom_range(0, 3) == 0);
      rx_valid      = 2'($urandom) & 2'($urandom);
      rx_data       = 16'($urandom);
      tx_ready      = 2'($urandom);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
